// File: rtl/downcounter_mmss.sv
// Four-digit BCD MM:SS countdown timer with load/start/pause control and a one-cycle done pulse.
// Optional macro DOWNCNT_AUTO_RELOAD_EN: reload from the last loaded value on reaching 00:00 and keep running.
module downcounter_mmss #(
  parameter logic [3:0] SEC_TENS_MAX = 4'd5,
  parameter logic [3:0] MIN_TENS_MAX = 4'd5,
  parameter logic [3:0] ONES_MAX     = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_mt,
  input  logic [3:0] ld_mo,
  input  logic [3:0] ld_st,
  input  logic [3:0] ld_so,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       zero,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q;
  logic [3:0] mt_d, mo_d, st_d, so_d;
  logic       done_q, done_d;

  logic [3:0] ld_mt_c, ld_mo_c, ld_st_c, ld_so_c;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;
  logic       b_so, b_st, b_mo, dec_zero;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign ld_mt_c = clamp(ld_mt, MIN_TENS_MAX);
  assign ld_mo_c = clamp(ld_mo, ONES_MAX);
  assign ld_st_c = clamp(ld_st, SEC_TENS_MAX);
  assign ld_so_c = clamp(ld_so, ONES_MAX);

  // Borrow ripples from seconds-ones upward; min_tens never borrows since 00:00 is never decremented.
  always_comb begin
    b_so   = (so_q == 4'd0);
    dec_so = b_so ? ONES_MAX : so_q - 4'd1;
    b_st   = b_so && (st_q == 4'd0);
    dec_st = b_so ? ((st_q == 4'd0) ? SEC_TENS_MAX : st_q - 4'd1) : st_q;
    b_mo   = b_st && (mo_q == 4'd0);
    dec_mo = b_st ? ((mo_q == 4'd0) ? ONES_MAX : mo_q - 4'd1) : mo_q;
    dec_mt = b_mo ? mt_q - 4'd1 : mt_q;
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) && (dec_st == 4'd0) && (dec_so == 4'd0);
  end

`ifdef DOWNCNT_AUTO_RELOAD_EN
  logic [3:0] sh_mt_q, sh_mo_q, sh_st_q, sh_so_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mt_q <= 4'd0;
      sh_mo_q <= 4'd0;
      sh_st_q <= 4'd0;
      sh_so_q <= 4'd0;
    end else if (load) begin
      sh_mt_q <= ld_mt_c;
      sh_mo_q <= ld_mo_c;
      sh_st_q <= ld_st_c;
      sh_so_q <= ld_so_c;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    done_d  = 1'b0;
    if (load) begin
      mt_d    = ld_mt_c;
      mo_d    = ld_mo_c;
      st_d    = ld_st_c;
      so_d    = ld_so_c;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (start && !pause && !zero) state_d = RUN;
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            mt_d = dec_mt;
            mo_d = dec_mo;
            st_d = dec_st;
            so_d = dec_so;
            if (dec_zero) begin
              done_d = 1'b1;
`ifdef DOWNCNT_AUTO_RELOAD_EN
              mt_d = sh_mt_q;
              mo_d = sh_mo_q;
              st_d = sh_st_q;
              so_d = sh_so_q;
`else
              state_d = DONE;
`endif
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign min_tens = mt_q;
  assign min_ones = mo_q;
  assign sec_tens = st_q;
  assign sec_ones = so_q;
  assign running  = (state_q == RUN);
  assign zero     = (mt_q == 4'd0) && (mo_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
  assign done     = done_q;

endmodule

// File: tb/tb_downcounter_mmss.sv
// Directed bench for downcounter_mmss; expected {digits,running,zero,done} go through a scoreboard queue.
module tb_downcounter_mmss;

  logic       clk, rst, tick, load, start, pause;
  logic [3:0] ld_mt, ld_mo, ld_st, ld_so;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, zero, done;

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  downcounter_mmss dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load),
    .ld_mt(ld_mt), .ld_mo(ld_mo), .ld_st(ld_st), .ld_so(ld_so),
    .start(start), .pause(pause),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .zero(zero), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] ev(input logic [3:0] mt, mo, st, so, input logic r, z, d);
    return {mt, mo, st, so, r, z, d};
  endfunction

  task automatic pop_check();
    sb_t         e;
    logic [18:0] obs;
    e   = sb_q.pop_front();
    obs = {min_tens, min_ones, sec_tens, sec_ones, running, zero, done};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then compare just after the next rising edge.
  task automatic step(input string tag, input logic ld, pa, sa, tk,
                      input logic [3:0] a, b, c, d, input logic [18:0] exp);
    sb_t e;
    @(negedge clk);
    load = ld; pause = pa; start = sa; tick = tk;
    ld_mt = a; ld_mo = b; ld_st = c; ld_so = d;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
    $display("step %-14s ld=%b pa=%b st=%b tk=%b -> %0d%0d:%0d%0d run=%b zero=%b done=%b",
             tag, ld, pa, sa, tk, min_tens, min_ones, sec_tens, sec_ones, running, zero, done);
  endtask

  task automatic check_now(input string tag, input logic [18:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    pop_check();
    $display("check %-14s -> %0d%0d:%0d%0d run=%b zero=%b done=%b",
             tag, min_tens, min_ones, sec_tens, sec_ones, running, zero, done);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    ld_mt = 4'd0; ld_mo = 4'd0; ld_st = 4'd0; ld_so = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_init", ev(0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0;

    // Borrow chain through three digits
    step("load_10:00", 1, 0, 0, 0, 1, 0, 0, 0, ev(1, 0, 0, 0, 0, 0, 0));
    step("start_10:00", 0, 0, 1, 0, 0, 0, 0, 0, ev(1, 0, 0, 0, 1, 0, 0));
    step("tick_09:59", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 9, 5, 9, 1, 0, 0));
    step("tick_09:58", 0, 0, 1, 1, 0, 0, 0, 0, ev(0, 9, 5, 8, 1, 0, 0));
    step("idle_09:58", 0, 0, 0, 0, 0, 0, 0, 0, ev(0, 9, 5, 8, 1, 0, 0));

    // Terminal count
    step("load_00:02", 1, 0, 0, 0, 0, 0, 0, 2, ev(0, 0, 0, 2, 0, 0, 0));
    step("start_00:02", 0, 0, 1, 0, 0, 0, 0, 0, ev(0, 0, 0, 2, 1, 0, 0));
    step("tick_00:01", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 0, 0, 1, 1, 0, 0));
`ifdef DOWNCNT_AUTO_RELOAD_EN
    step("reload_00:02", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 0, 0, 2, 1, 0, 1));
    step("reload_pulse", 0, 0, 0, 0, 0, 0, 0, 0, ev(0, 0, 0, 2, 1, 0, 0));
    step("reload_tick", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 0, 0, 1, 1, 0, 0));
`else
    step("tick_00:00", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 1));
    step("done_clear", 0, 0, 0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0));
    step("done_tick", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0));
    step("done_start", 0, 0, 1, 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0));
`endif

    // Clamping and refusing to start at zero
    step("load_clamp", 1, 0, 0, 0, 7, 12, 9, 15, ev(5, 9, 5, 9, 0, 0, 0));
    step("load_00:00", 1, 0, 0, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0));
    step("start_zero", 0, 0, 1, 0, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0));

    // Pause and priority
    step("load_05:30", 1, 0, 0, 0, 0, 5, 3, 0, ev(0, 5, 3, 0, 0, 0, 0));
    step("start_05:30", 0, 0, 1, 0, 0, 0, 0, 0, ev(0, 5, 3, 0, 1, 0, 0));
    step("pause_tick", 0, 1, 0, 1, 0, 0, 0, 0, ev(0, 5, 3, 0, 0, 0, 0));
    step("paused_tick", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 5, 3, 0, 0, 0, 0));
    step("pause_start", 0, 1, 1, 0, 0, 0, 0, 0, ev(0, 5, 3, 0, 0, 0, 0));
    step("resume", 0, 0, 1, 0, 0, 0, 0, 0, ev(0, 5, 3, 0, 1, 0, 0));
    step("tick_05:29", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 5, 2, 9, 1, 0, 0));
    step("load_over_all", 1, 1, 1, 1, 0, 3, 0, 0, ev(0, 3, 0, 0, 0, 0, 0));
    step("start_03:00", 0, 0, 1, 0, 0, 0, 0, 0, ev(0, 3, 0, 0, 1, 0, 0));
    step("tick_02:59", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 2, 5, 9, 1, 0, 0));

    // Asynchronous reset in the middle of a run
    step("load_12:34", 1, 0, 0, 0, 1, 2, 3, 4, ev(1, 2, 3, 4, 0, 0, 0));
    step("start_12:34", 0, 0, 1, 0, 0, 0, 0, 0, ev(1, 2, 3, 4, 1, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    check_now("async_reset", ev(0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_tick", 0, 0, 1, 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0));
    step("post_rst_idle", 0, 0, 0, 1, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 1, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/downcounter_mmss.md
Name: downcounter_mmss

Overview:
- Four-digit BCD countdown timer (MM:SS) for the lab timer display path; counts down in the other direction from the existing per-digit up-counters.
- Each digit borrows from the next, instead of carrying into it.
- Controlled by load/start/pause; decrements on an external 1 Hz enable tick.
- Drives the seven-segment digit mux directly and flags completion with a one-cycle done pulse.

Parameters:
- SEC_TENS_MAX, 5, maximum value of seconds-tens digit; borrow into it reloads it to this value.
- MIN_TENS_MAX, 5, maximum value of minutes-tens digit; load values above it are clamped.
- ONES_MAX, 9, maximum value of both ones digits; borrow into them reloads them to this value.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle count enable (1 Hz strobe from prescaler).
- load  input  1  load ld_mt/ld_mo/ld_st/ld_so into the digits.
- ld_mt  input  4  load value, minutes tens.
- ld_mo  input  4  load value, minutes ones.
- ld_st  input  4  load value, seconds tens.
- ld_so  input  4  load value, seconds ones.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- min_tens  output  4  current minutes-tens digit (registered).
- min_ones  output  4  current minutes-ones digit (registered).
- sec_tens  output  4  current seconds-tens digit (registered).
- sec_ones  output  4  current seconds-ones digit (registered).
- running  output  1  high while state is RUN (registered state decode).
- zero  output  1  combinational; high when all four digits are 0.
- done  output  1  registered one-cycle pulse on reaching 00:00.

Behaviour:
- Reset (rst=1, async): all digits 0, state IDLE, running=0, done=0; zero=1 follows from the digits.
- States: IDLE, RUN, PAUSE, DONE.
- Priority each cycle: load > pause > start > tick.
- load (any state): digits take their clamped ld_* values next edge and the state goes to IDLE.
  - Clamping: each ones digit saturates at ONES_MAX, sec_tens at SEC_TENS_MAX, min_tens at MIN_TENS_MAX.
  - Any tick, start or pause in the same cycle is ignored.
- IDLE: start with zero=0 and no pause -> RUN. start with zero=1 -> stays IDLE.
- RUN:
  - pause -> PAUSE, and no decrement that cycle.
  - Otherwise tick decrements the count by one second.
- PAUSE: start (no pause) -> RUN if zero=0. tick is ignored.
- DONE: holds 00:00. start is ignored; only load leaves DONE.
- Decrement chain, applied only in RUN with tick=1, load=0, pause=0:
  - sec_ones 0 -> ONES_MAX with borrow, else minus 1.
  - sec_tens: on borrow, 0 -> SEC_TENS_MAX with borrow, else minus 1.
  - min_ones: on borrow, 0 -> ONES_MAX with borrow, else minus 1.
  - min_tens: on borrow, minus 1.
  - A borrow never leaves min_tens, because 00:00 is never decremented.
- Terminal: a decrement whose result is 00:00 -> state DONE next edge; done=1 for exactly that first DONE cycle, then 0.
- A tick while RUN at 00:00 cannot occur, because RUN is never entered or held at zero.
- Latency: digit outputs change on the clock edge after the qualifying tick/load. running updates on the same edge as the state.
- start held high continuously: no further effect once in RUN.

Optional Feature:
- Macro: DOWNCNT_AUTO_RELOAD_EN.
- Defined:
  - A shadow register captures the clamped load values on every load.
  - A decrement that reaches 00:00 instead reloads the digits from the shadow on that same edge.
  - done pulses for one cycle, and the state stays RUN; DONE is unreachable.
  - Reset clears the shadow to 00:00.
- Undefined: no shadow register; terminal behaviour is as in Behaviour.

Test Plan:
- Reset: assert rst mid-RUN at 12:34 -> digits 00:00, running=0, done=0, zero=1 immediately (async), and they stay so until load.
- Borrow chain: load 10:00, start, 1 tick -> 09:59. Second tick -> 09:58. No done.
- Terminal: load 00:02, start, 2 ticks -> 00:01, then 00:00. done=1 for one cycle, state DONE, running=0. Further ticks and start leave 00:00 with done=0.
- Clamp/zero start: load ld_mt=7, ld_mo=12, ld_st=9, ld_so=15 -> 59:59. Load 00:00 then start -> stays IDLE, running=0.
- Pause/priority:
  - At 05:30 RUN, pause+tick same cycle -> PAUSE, still 05:30. tick while PAUSE -> 05:30. start -> RUN; tick -> 05:29.
  - load 03:00 with start+tick same cycle -> 03:00, IDLE.
- Auto-reload (macro defined): load 00:02, start, 2 ticks -> 00:01, then 00:02 (reloaded), done pulses once, running stays 1. Next tick -> 00:01.
